// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   owner_e          : which requester owns the response slot of the next cycle
//   ADDR_W_DEFAULT   : default word-address width of the shared memory
//   MEM_WORDS        : depth of the shared memory
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 6;
  localparam int unsigned MEM_WORDS      = 64;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count up by one unless already at Limit
//   clr      : return to zero (wins over inc)
//   count    : current value
module sat_counter #(
  parameter int unsigned     Width = 4,
  parameter logic [Width-1:0] Limit = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != Limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read memory between instruction fetch and
// the load/store unit. One access is granted per cycle; the response appears
// the following cycle. Data normally wins; after MAX_STARVE consecutive denied
// fetch cycles fetch wins the next contention.
//   if_*        : fetch request (req/addr), grant, response (ready/rdata), stall_if
//   d_*         : data request (req/we/be/addr/wdata), grant, response (ready/rdata)
//   mem_*       : memory strobe, write enable, byte enables, word address, data
//   conflict_cnt: saturating count of cycles where both sides requested
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);

  logic [StarveW-1:0] starve_cnt;
  logic               starve_full;
  owner_e             owner_q, owner_d;
  logic               load_q, load_d;
  logic [31:0]        if_rdata_q, d_rdata_q;

  // Low byte-offset and high address bits never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign starve_full = (starve_cnt == StarveW'(MAX_STARVE));

  // Grant; both grants are forced low while in reset.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (d_req && !(if_req && starve_full)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign stall_if = if_req & ~if_gnt;

  // Memory issue
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = d_gnt ? d_be : 4'b0000;
    mem_wdata = rst ? 32'd0 : d_wdata;
    mem_addr  = '0;
    if (d_gnt) begin
      mem_addr = d_addr[ADDR_W+1:2];
    end else if (if_gnt) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end
  end

  // Owner FSM: next owner is purely the winner of this cycle.
  always_comb begin
    owner_d = OwnNone;
    load_d  = 1'b0;
    if (if_gnt) begin
      owner_d = OwnIf;
    end else if (d_gnt) begin
      owner_d = OwnD;
      load_d  = ~d_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OwnNone;
      load_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      load_q  <= load_d;
    end
  end

  // Responses: pass memory data through in the ready cycle, hold otherwise.
  assign if_ready = (owner_q == OwnIf);
  assign d_ready  = (owner_q == OwnD);
  assign if_rdata = if_ready ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_ready ? (load_q ? mem_rdata : 32'd0) : d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      if (if_ready) if_rdata_q <= if_rdata;
      if (d_ready)  d_rdata_q  <= d_rdata;
    end
  end

  sat_counter #(
    .Width (StarveW),
    .Limit (StarveW'(MAX_STARVE))
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_req & ~if_gnt),
    .clr   (if_gnt | ~if_req),
    .count (starve_cnt)
  );

  sat_counter #(
    .Width (CNT_W),
    .Limit ({CNT_W{1'b1}})
  ) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_req & d_req),
    .clr   (1'b0),
    .count (conflict_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 6;
  localparam int MAX_STARVE = 4;
  localparam int CNT_W      = 4;
  localparam int CONF_MAX   = (1 << CNT_W) - 1;

  logic              clk, rst;
  logic              if_req, if_gnt, if_ready, stall_if;
  logic [31:0]       if_addr, if_rdata;
  logic              d_req, d_we, d_gnt, d_ready;
  logic [3:0]        d_be;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .MAX_STARVE (MAX_STARVE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .stall_if     (stall_if),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_be         (d_be),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory attached to the port (synchronous read, byte-enabled write).
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          starve_run;  // consecutive cycles fetch has been refused
  int          conf;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t        if_q[$], d_q[$];
  exp_t        if_e, d_e;
  logic [31:0] last_if, last_d;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ready) begin
        if (if_q.size() == 0) begin
          check("if_ready_spurious", 32'(if_ready), 32'd0);
        end else begin
          if_e = if_q.pop_front();
          check("if_ready_cycle", cyc, if_e.cyc);
          check("if_rdata", if_rdata, if_e.data);
          last_if = if_e.data;
        end
      end else begin
        if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
          check("if_ready", 32'(if_ready), 32'd1);
          void'(if_q.pop_front());
        end
        check("if_rdata_hold", if_rdata, last_if);
      end
      if (d_ready) begin
        if (d_q.size() == 0) begin
          check("d_ready_spurious", 32'(d_ready), 32'd0);
        end else begin
          d_e = d_q.pop_front();
          check("d_ready_cycle", cyc, d_e.cyc);
          check("d_rdata", d_rdata, d_e.data);
          last_d = d_e.data;
        end
      end else begin
        if (d_q.size() > 0 && d_q[0].cyc <= cyc) begin
          check("d_ready", 32'(d_ready), 32'd1);
          void'(d_q.pop_front());
        end
        check("d_rdata_hold", d_rdata, last_d);
      end
    end
  end

  // One cycle of stimulus plus issue-side checks and model update.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] dwd);
    logic       win_if, win_d;
    logic [5:0] wa;
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    check("conflict_cnt", 32'(conflict_cnt), conf);
    win_if = ir && (!dr || starve_run >= MAX_STARVE);
    win_d  = dr && !win_if;
    wa     = win_d ? da[7:2] : ia[7:2];
    check("gnt_en_we_stall", 32'({if_gnt, d_gnt, mem_en, mem_we, stall_if}),
          32'({win_if, win_d, win_if || win_d, win_d && dw, ir && !win_if}));
    check("mem_be", 32'(mem_be), win_d ? 32'(be) : 32'd0);
    if (win_if || win_d) check("mem_addr", 32'(mem_addr), 32'(wa));
    if (win_d && dw) check("mem_wdata", mem_wdata, dwd);
    if (win_if) begin
      if_q.push_back('{cyc: cyc + 1, data: ref_mem[wa]});
    end else if (win_d) begin
      if (dw) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
        d_q.push_back('{cyc: cyc + 1, data: 32'd0});
      end else begin
        d_q.push_back('{cyc: cyc + 1, data: ref_mem[wa]});
      end
    end
    if (ir && dr && conf < CONF_MAX) conf++;
    if (ir && !win_if) starve_run = (starve_run < MAX_STARVE) ? starve_run + 1 : MAX_STARVE;
    else starve_run = 0;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Reset asserted just after a clock edge, with requests active to show gating.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    @(negedge clk);
    check("rst_gnt_mem", 32'({if_gnt, d_gnt, mem_en, mem_we, mem_be}), 32'd0);
    check("rst_ready", 32'({if_ready, d_ready}), 32'd0);
    check("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    if_q.delete(); d_q.delete();
    starve_run = 0; conf = 0; last_if = 32'd0; last_d = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'd0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    starve_run = 0; conf = 0; last_if = 32'd0; last_d = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[2] = 32'h0000_0417;
    ref_mem[2] = 32'h0000_0417;
    apply_reset();

    // Fetch only from word 2
    step(1'b1, 32'h08, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    idle();
    // Store then load at word 4
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hABCD_E000);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    idle();
    // Byte store with misaligned address, then read back the merged word
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'b0100, 32'h13, 32'h1122_3344);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    idle();
    // Load granted, then reset before its response
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    apply_reset();

    // Contention for 10 cycles: fetch wins every 5th cycle
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, 4'h0, $urandom, 32'd0);
      check("contention_if_gnt", 32'(if_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    idle();
    check("conflict_after_10", 32'(conflict_cnt), 32'd10);

    // Saturation of the conflict counter
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0, 4'h0, $urandom, 32'd0);
    idle();
    check("conflict_saturated", 32'(conflict_cnt), 32'd15);

    // Random traffic
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      if (i == 250) apply_reset();
    end
    repeat (3) idle();
    check("if_q_drained", if_q.size(), 32'd0);
    check("d_q_drained", d_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
